// File: rtl/gfx_pkg.sv
// Shared definitions for the 160x120 drawing pipeline: grid geometry,
// colour encoding and the fill-engine state type.
package gfx_pkg;

  localparam int X_BITS      = 8;
  localparam int Y_BITS      = 7;
  localparam int COLOUR_BITS = 3;

  // Held one bit wider than a coordinate so the raw sum ax/ay can be compared directly.
  localparam logic [X_BITS:0] X_MAX = (X_BITS+1)'(160);
  localparam logic [Y_BITS:0] Y_MAX = (Y_BITS+1)'(120);

  localparam logic [COLOUR_BITS-1:0] BLACK = COLOUR_BITS'(0);
  localparam logic [COLOUR_BITS-1:0] WHITE = COLOUR_BITS'(7);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FINISH
  } fill_state_t;

endpackage

// File: rtl/xy_scan_counter.sv
// Two-dimensional raster offset counter: xoff sweeps 0..w-1, then wraps
// and advances yoff through 0..h-1. last flags the final offset pair.
module xy_scan_counter
  import gfx_pkg::*;
(
  input  logic              vga_clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic              load,
  input  logic [X_BITS-1:0] w,
  input  logic [Y_BITS-1:0] h,
  output logic [X_BITS-1:0] xoff,
  output logic [Y_BITS-1:0] yoff,
  output logic              last
);

  logic x_end;
  logic y_end;

  assign x_end = (xoff == w - X_BITS'(1));
  assign y_end = (yoff == h - Y_BITS'(1));
  assign last  = x_end && y_end;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      xoff <= '0;
      yoff <= '0;
    end else if (load) begin
      xoff <= '0;
      yoff <= '0;
    end else if (enable) begin
      if (x_end) begin
        xoff <= '0;
        yoff <= y_end ? '0 : yoff + Y_BITS'(1);
      end else begin
        xoff <= xoff + X_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle / full-screen clear engine: latches a command, walks its pixels
// in raster order at one per clock and emits clipped video-memory writes.
module rect_fill_engine
  import gfx_pkg::*;
(
  input  logic                   vga_clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   clear,
  input  logic [X_BITS-1:0]      x0,
  input  logic [Y_BITS-1:0]      y0,
  input  logic [X_BITS-1:0]      width,
  input  logic [Y_BITS-1:0]      height,
  input  logic [COLOUR_BITS-1:0] colour_in,
  output logic                   busy,
  output logic                   done,
  output logic                   plot,
  output logic [X_BITS-1:0]      x_out,
  output logic [Y_BITS-1:0]      y_out,
  output logic [COLOUR_BITS-1:0] colour_out
);

  fill_state_t state, state_next;

  logic [X_BITS-1:0]      x0_r, w_r, xoff;
  logic [Y_BITS-1:0]      y0_r, h_r, yoff;
  logic [COLOUR_BITS-1:0] colour_r;
  logic [X_BITS:0]        ax;
  logic [Y_BITS:0]        ay;
  logic accept_start, accept_clear, scan_en, last, visible;

  xy_scan_counter u_scan (
    .vga_clock (vga_clock),
    .resetn    (resetn),
    .enable    (scan_en),
    .load      (accept_start || accept_clear),
    .w         (w_r),
    .h         (h_r),
    .xoff      (xoff),
    .yoff      (yoff),
    .last      (last)
  );

  assign ax      = {1'b0, x0_r} + {1'b0, xoff};
  assign ay      = {1'b0, y0_r} + {1'b0, yoff};
  assign visible = (ax < X_MAX) && (ay < Y_MAX);

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every always_comb output gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    accept_clear = 1'b0;
    scan_en      = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          accept_clear = 1'b1;
          state_next   = FILL;
        end else if (start) begin
          accept_start = 1'b1;
          state_next   = (width == '0 || height == '0) ? FINISH : FILL;
        end
      end
      FILL: begin
        scan_en = 1'b1;
        if (last) state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      x0_r     <= '0;
      y0_r     <= '0;
      w_r      <= '0;
      h_r      <= '0;
      colour_r <= '0;
    end else if (accept_clear) begin
      x0_r     <= '0;
      y0_r     <= '0;
      w_r      <= X_MAX[X_BITS-1:0];
      h_r      <= Y_MAX[Y_BITS-1:0];
      colour_r <= BLACK;
    end else if (accept_start) begin
      x0_r     <= x0;
      y0_r     <= y0;
      w_r      <= width;
      h_r      <= height;
      colour_r <= colour_in;
    end
  end

  // Coordinates only move on a visible pixel so clipped cycles leave the last write address intact.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
    end else begin
      busy       <= (state_next == FILL);
      done       <= (state == FINISH);
      plot       <= (state == FILL) && visible;
      colour_out <= colour_r;
      if (state == FILL && visible) begin
        x_out <= ax[X_BITS-1:0];
        y_out <= ay[Y_BITS-1:0];
      end
    end
  end

endmodule
